// File: rtl/rv32i_dmem_responder.sv
// Data-side responder for the RV32I core: byte-writable data RAM plus an MMIO window (GPIO, error status).
// Defining DMEM_MMIO_TIMER_EN adds the 64-bit machine timer, its compare interrupt and the atomic-read HI shadow.
module rv32i_dmem_responder #(
  parameter logic [31:0] DMEM_BASE        = 32'h1001_0000,
  parameter int          DMEM_DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE        = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  Byte_Enable,
  output logic [31:0] ReadData,
  output logic [15:0] gpio_out,
  output logic        timer_irq,
  output logic        bus_err
);
  localparam int          AW        = $clog2(DMEM_DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DMEM_DEPTH_WORDS);

  localparam logic [3:0] OFF_GPIO     = 4'h0;
  localparam logic [3:0] OFF_MTIME_LO = 4'h4;
  localparam logic [3:0] OFF_MTIME_HI = 4'h5;
  localparam logic [3:0] OFF_CMP_LO   = 4'h6;
  localparam logic [3:0] OFF_CMP_HI   = 4'h7;
  localparam logic [3:0] OFF_ERR      = 4'h8;

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldWord;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = newWord[8*i +: 8];
    return res;
  endfunction

  logic [31:0]   ramOff;
  logic          ramHit;
  logic          mmioHit;
  logic          unmapped;
  logic [AW-1:0] ramIdx;
  logic [3:0]    mmioOff;
  logic          mmioWe;
  logic          ramWe;

  assign ramOff   = Addr - DMEM_BASE;
  assign ramHit   = (Addr >= DMEM_BASE) && (ramOff < RAM_BYTES);
  assign ramIdx   = ramOff[AW+1:2];
  assign mmioHit  = (Addr[31:6] == MMIO_BASE[31:6]);
  assign mmioOff  = Addr[5:2];
  assign unmapped = !ramHit && !mmioHit;
  assign mmioWe   = MemWrite && mmioHit;
  // A store coinciding with reset assertion must not reach the unreset RAM either.
  assign ramWe    = MemWrite && ramHit && n_rst;

  // Stage p0: RAM array, read-first on a same-word collision
  logic [31:0] ram [DMEM_DEPTH_WORDS];
  logic [31:0] ramWord_p0;

  always_ff @(posedge clk) begin
    ramWord_p0 <= ram[ramIdx];
    if (ramWe)
      for (int i = 0; i < 4; i++)
        if (Byte_Enable[i]) ram[ramIdx][8*i +: 8] <= WriteData[8*i +: 8];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gpio_out <= '0;
    end else if (mmioWe && mmioOff == OFF_GPIO) begin
      if (Byte_Enable[0]) gpio_out[7:0]  <= WriteData[7:0];
      if (Byte_Enable[1]) gpio_out[15:8] <= WriteData[15:8];
    end
  end

  logic        errFlag;
  logic [15:0] errCnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      errFlag <= 1'b0;
      errCnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= MemWrite && unmapped;
      if (MemWrite && unmapped) begin
        errFlag <= 1'b1;
        if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
      end else if (mmioWe && mmioOff == OFF_ERR && Byte_Enable[0] && WriteData[0]) begin
        errFlag <= 1'b0;
      end
    end
  end

  logic [31:0] timerRd;

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] mtimeLo;
  logic [31:0] mtimeHi;
  logic [31:0] cmpLo;
  logic [31:0] cmpHi;
  logic [31:0] hiShadow;
  logic        wrLo;
  logic        wrHi;
  logic        wrCmpLo;
  logic        wrCmpHi;

  assign wrLo    = mmioWe && mmioOff == OFF_MTIME_LO;
  assign wrHi    = mmioWe && mmioOff == OFF_MTIME_HI;
  assign wrCmpLo = mmioWe && mmioOff == OFF_CMP_LO;
  assign wrCmpHi = mmioWe && mmioOff == OFF_CMP_HI;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mtimeLo   <= '0;
      mtimeHi   <= '0;
      cmpLo     <= '1;
      cmpHi     <= '1;
      hiShadow  <= '0;
      timer_irq <= 1'b0;
    end else begin
      mtimeLo <= wrLo ? mergeLanes(mtimeLo, WriteData, Byte_Enable) : mtimeLo + 32'd1;
      if (wrHi)
        mtimeHi <= mergeLanes(mtimeHi, WriteData, Byte_Enable);
      else if (!wrLo && mtimeLo == '1)
        mtimeHi <= mtimeHi + 32'd1;
      if (wrCmpLo) cmpLo <= mergeLanes(cmpLo, WriteData, Byte_Enable);
      if (wrCmpHi) cmpHi <= mergeLanes(cmpHi, WriteData, Byte_Enable);
      // Any LO read-decode snapshots HI so a following HI read pairs with it atomically.
      if (mmioHit && mmioOff == OFF_MTIME_LO) hiShadow <= mtimeHi;
      timer_irq <= {mtimeHi, mtimeLo} >= {cmpHi, cmpLo};
    end
  end

  always_comb begin
    timerRd = '0;
    case (mmioOff)
      OFF_MTIME_LO: timerRd = mtimeLo;
      OFF_MTIME_HI: timerRd = hiShadow;
      OFF_CMP_LO:   timerRd = cmpLo;
      OFF_CMP_HI:   timerRd = cmpHi;
      default:      timerRd = '0;
    endcase
  end
`else
  assign timerRd   = '0;
  assign timer_irq = 1'b0;
`endif

  logic [31:0] mmioRd;

  always_comb begin
    mmioRd = '0;
    case (mmioOff)
      OFF_GPIO:                                         mmioRd = {16'h0, gpio_out};
      OFF_MTIME_LO, OFF_MTIME_HI, OFF_CMP_LO, OFF_CMP_HI: mmioRd = timerRd;
      OFF_ERR:                                          mmioRd = {errCnt, 15'h0, errFlag};
      default:                                          mmioRd = '0;
    endcase
  end

  // Stage p0: registered read path; the select is reset so ReadData is 0 while the RAM word is not
  logic        ramSel_p0;
  logic [31:0] mmioWord_p0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ramSel_p0   <= 1'b0;
      mmioWord_p0 <= '0;
    end else begin
      ramSel_p0   <= ramHit;
      mmioWord_p0 <= mmioHit ? mmioRd : '0;
    end
  end

  assign ReadData = ramSel_p0 ? ramWord_p0 : mmioWord_p0;
endmodule
